// File: rtl/ctrl_pkg.sv
// Shared encodings for the multicycle RV32I control path: opcodes, funct3 codes,
// access sizes, writeback sources, FSM states and the decoded-field bundle.
package ctrl_pkg;

    localparam logic [6:0] OPC_LOAD     = 7'b0000011;
    localparam logic [6:0] OPC_MISC_MEM = 7'b0001111;
    localparam logic [6:0] OPC_OP_IMM   = 7'b0010011;
    localparam logic [6:0] OPC_AUIPC    = 7'b0010111;
    localparam logic [6:0] OPC_STORE    = 7'b0100011;
    localparam logic [6:0] OPC_OP       = 7'b0110011;
    localparam logic [6:0] OPC_LUI      = 7'b0110111;
    localparam logic [6:0] OPC_BRANCH   = 7'b1100011;
    localparam logic [6:0] OPC_JALR     = 7'b1100111;
    localparam logic [6:0] OPC_JAL      = 7'b1101111;
    localparam logic [6:0] OPC_SYSTEM   = 7'b1110011;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;

    localparam logic [2:0] F3_SB  = 3'b000;
    localparam logic [2:0] F3_SH  = 3'b001;
    localparam logic [2:0] F3_SW  = 3'b010;

    localparam logic [2:0] F3_PRIV   = 3'b000;
    localparam logic [2:0] F3_CSRRW  = 3'b001;
    localparam logic [2:0] F3_CSRRS  = 3'b010;
    localparam logic [2:0] F3_CSRRC  = 3'b011;
    localparam logic [2:0] F3_RSVD4  = 3'b100;
    localparam logic [2:0] F3_CSRRWI = 3'b101;
    localparam logic [2:0] F3_CSRRSI = 3'b110;
    localparam logic [2:0] F3_CSRRCI = 3'b111;

    localparam logic [1:0] SIZE_BYTE = 2'b00;
    localparam logic [1:0] SIZE_HALF = 2'b01;
    localparam logic [1:0] SIZE_WORD = 2'b10;

    localparam logic [1:0] WB_ALU = 2'b00;
    localparam logic [1:0] WB_MEM = 2'b01;
    localparam logic [1:0] WB_PC4 = 2'b10;
    localparam logic [1:0] WB_IMM = 2'b11;

    typedef enum logic [2:0] {
        ST_FETCH  = 3'd0,
        ST_DECODE = 3'd1,
        ST_EXEC   = 3'd2,
        ST_MEM    = 3'd3,
        ST_WB     = 3'd4,
        ST_TRAP   = 3'd5
    } state_t;

    typedef struct packed {
        logic [6:0] opcode;
        logic [4:0] rd;
        logic [2:0] funct3;
        logic [4:0] rs1;
        logic       is_load;
        logic       is_store;
        logic       is_csr;
        logic       illegal;
    } decoded_t;

    // Load and store funct3 share the size in bits [1:0]; only legal codes reach MEM.
    function automatic logic [1:0] access_size(input logic [2:0] funct3);
        case (funct3[1:0])
            2'b00:   access_size = SIZE_BYTE;
            2'b01:   access_size = SIZE_HALF;
            default: access_size = SIZE_WORD;
        endcase
    endfunction

    function automatic logic csr_is_swap(input logic [2:0] funct3);
        csr_is_swap = (funct3 == F3_CSRRW) || (funct3 == F3_CSRRWI);
    endfunction

endpackage

// File: rtl/ctrl_decode.sv
// Combinational classification of the latched instruction fields into the
// decoded-field bundle consumed by the control FSM.
module ctrl_decode
    import ctrl_pkg::*;
(
    input  logic [6:0] opcode,
    input  logic [4:0] rd,
    input  logic [2:0] funct3,
    input  logic [4:0] rs1,
    output decoded_t   dec
);

    always_comb begin
        dec        = '0;
        dec.opcode = opcode;
        dec.rd     = rd;
        dec.funct3 = funct3;
        dec.rs1    = rs1;
        case (opcode)
            OPC_LOAD: begin
                dec.is_load = 1'b1;
                dec.illegal = (funct3 == 3'd3) || (funct3 == 3'd6) || (funct3 == 3'd7);
            end
            OPC_STORE: begin
                dec.is_store = 1'b1;
                dec.illegal  = (funct3 > F3_SW);
            end
            OPC_SYSTEM: begin
                // ECALL/EBREAK and the reserved funct3 are not handled by this core.
                dec.is_csr  = (funct3 != F3_PRIV) && (funct3 != F3_RSVD4);
                dec.illegal = (funct3 == F3_PRIV) || (funct3 == F3_RSVD4);
            end
            OPC_OP, OPC_OP_IMM, OPC_LUI, OPC_AUIPC,
            OPC_JAL, OPC_JALR, OPC_BRANCH, OPC_MISC_MEM: begin
                dec.illegal = 1'b0;
            end
            default: begin
                dec.illegal = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/multicycle_control_fsm.sv
// FETCH/DECODE/EXEC/MEM/WB sequencer for the multicycle RV32I core.
// Define MEM_TIMEOUT_EN to fault and trap when an IMEM/DMEM ack never arrives.
module multicycle_control_fsm
    import ctrl_pkg::*;
#(
    parameter int MEM_TIMEOUT = 16,
    parameter int CNT_W       = $clog2(MEM_TIMEOUT + 1)
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic [31:0] i_instr,
    output logic        o_imem_req,
    input  logic        i_imem_ack,
    output logic        o_dmem_req,
    input  logic        i_dmem_ack,
    output logic        o_mem_read,
    output logic        o_mem_write,
    output logic [1:0]  o_d_size,
    output logic        o_d_unsigned,
    output logic        o_ir_write,
    output logic        o_pc_write,
    output logic        o_reg_write,
    output logic [1:0]  o_mem_to_reg,
    output logic        o_csr_read,
    output logic        o_csr_write,
    output logic        o_illegal,
    output logic        o_mem_fault,
    input  logic        i_trap_clear,
    output logic [2:0]  o_state
);

    state_t     state;
    logic [6:0] opcode_q;
    logic [4:0] rd_q;
    logic [2:0] funct3_q;
    logic [4:0] rs1_q;
    logic       illegal_q;
    decoded_t   dec;

    logic unused_instr_hi;
    assign unused_instr_hi = ^i_instr[31:20];

`ifdef MEM_TIMEOUT_EN
    logic [CNT_W-1:0] wait_cnt;
    logic             fault_q;
    logic             limit_hit;
    assign limit_hit   = (wait_cnt == CNT_W'(MEM_TIMEOUT));
    assign o_mem_fault = fault_q;
`else
    logic [CNT_W-1:0] unused_timeout;
    assign unused_timeout = CNT_W'(MEM_TIMEOUT);
    assign o_mem_fault    = 1'b0;
`endif

    ctrl_decode u_decode (
        .opcode (opcode_q),
        .rd     (rd_q),
        .funct3 (funct3_q),
        .rs1    (rs1_q),
        .dec    (dec)
    );

    // The wait counter only survives consecutive waiting cycles, so clearing it
    // every other cycle is the same as clearing it on entry to FETCH or MEM.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state     <= ST_FETCH;
            opcode_q  <= '0;
            rd_q      <= '0;
            funct3_q  <= '0;
            rs1_q     <= '0;
            illegal_q <= 1'b0;
`ifdef MEM_TIMEOUT_EN
            wait_cnt  <= '0;
            fault_q   <= 1'b0;
`endif
        end else begin
`ifdef MEM_TIMEOUT_EN
            wait_cnt <= '0;
`endif
            case (state)
                ST_FETCH: begin
                    if (i_imem_ack) begin
                        opcode_q <= i_instr[6:0];
                        rd_q     <= i_instr[11:7];
                        funct3_q <= i_instr[14:12];
                        rs1_q    <= i_instr[19:15];
                        state    <= ST_DECODE;
                    end
`ifdef MEM_TIMEOUT_EN
                    else if (limit_hit) begin
                        fault_q <= 1'b1;
                        state   <= ST_TRAP;
                    end else begin
                        wait_cnt <= wait_cnt + CNT_W'(1);
                    end
`endif
                end
                ST_DECODE: begin
                    if (dec.illegal) begin
                        illegal_q <= 1'b1;
                        state     <= ST_TRAP;
                    end else begin
                        state <= ST_EXEC;
                    end
                end
                ST_EXEC: begin
                    state <= (dec.is_load || dec.is_store) ? ST_MEM : ST_WB;
                end
                ST_MEM: begin
                    if (i_dmem_ack) begin
                        state <= dec.is_load ? ST_WB : ST_FETCH;
                    end
`ifdef MEM_TIMEOUT_EN
                    else if (limit_hit) begin
                        fault_q <= 1'b1;
                        state   <= ST_TRAP;
                    end else begin
                        wait_cnt <= wait_cnt + CNT_W'(1);
                    end
`endif
                end
                ST_WB: begin
                    state <= ST_FETCH;
                end
                ST_TRAP: begin
                    if (i_trap_clear) begin
                        illegal_q <= 1'b0;
`ifdef MEM_TIMEOUT_EN
                        fault_q   <= 1'b0;
`endif
                        state     <= ST_FETCH;
                    end
                end
                default: begin
                    state <= ST_FETCH;
                end
            endcase
        end
    end

    assign o_illegal = illegal_q;
    assign o_state   = state;

    // Strobes follow the state and latched fields; the IR and store-completion
    // PC strobes must coincide with their ack cycle, and reset silences all.
    always_comb begin
        o_imem_req   = 1'b0;
        o_dmem_req   = 1'b0;
        o_mem_read   = 1'b0;
        o_mem_write  = 1'b0;
        o_d_size     = SIZE_BYTE;
        o_d_unsigned = 1'b0;
        o_ir_write   = 1'b0;
        o_pc_write   = 1'b0;
        o_reg_write  = 1'b0;
        o_mem_to_reg = WB_ALU;
        o_csr_read   = 1'b0;
        o_csr_write  = 1'b0;
        if (i_rst_n) begin
            case (state)
                ST_FETCH: begin
                    o_imem_req = 1'b1;
                    o_ir_write = i_imem_ack;
                end
                ST_MEM: begin
                    o_dmem_req   = 1'b1;
                    o_mem_read   = dec.is_load;
                    o_mem_write  = dec.is_store;
                    o_d_size     = access_size(dec.funct3);
                    o_d_unsigned = dec.is_load && dec.funct3[2];
                    o_pc_write   = dec.is_store && i_dmem_ack;
                end
                ST_WB: begin
                    o_pc_write = 1'b1;
                    case (dec.opcode)
                        OPC_OP, OPC_OP_IMM, OPC_AUIPC: begin
                            o_reg_write  = 1'b1;
                            o_mem_to_reg = WB_ALU;
                        end
                        OPC_LOAD: begin
                            o_reg_write  = 1'b1;
                            o_mem_to_reg = WB_MEM;
                        end
                        OPC_JAL, OPC_JALR: begin
                            o_reg_write  = 1'b1;
                            o_mem_to_reg = WB_PC4;
                        end
                        OPC_LUI: begin
                            o_reg_write  = 1'b1;
                            o_mem_to_reg = WB_IMM;
                        end
                        OPC_SYSTEM: begin
                            o_reg_write = 1'b1;
                            if (csr_is_swap(dec.funct3)) begin
                                o_csr_write = 1'b1;
                                o_csr_read  = (dec.rd != 5'd0);
                            end else begin
                                o_csr_read  = 1'b1;
                                o_csr_write = (dec.rs1 != 5'd0);
                            end
                        end
                        default: begin
                            o_reg_write = 1'b0;
                        end
                    endcase
                end
                default: begin
                    o_imem_req = 1'b0;
                end
            endcase
        end
    end

endmodule
